mux_scan_ctrl: RTL

Sequencing controller that sits directly in front of the 4-to-1, 2-bit-wide select mux (`mux241`). It drives the mux select, waits a programmable settle time per slot, and samples the mux output. It reassembles the four 2-bit slices into the original 8-bit input word and hands that word downstream on a valid/ready handshake. It serves as the self-check and readout stage for the mux on the board and in simulation.

---
 rtl/mux_scan_pkg.sv | 6 +
 rtl/mux241.sv | 17 +
 rtl/settle_timer.sv | 28 ++
 rtl/mux_scan_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan controller.
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [1:0] SLOT_LAST = 2'd3;
  localparam int CNT_W = 8;
endpackage

// File: rtl/mux241.sv
// 4-to-1 select of 2-bit slices; the pair order is swapped (y[1]=a[2s], y[0]=a[2s+1]).
module mux241 (
  input  logic [7:0] a,
  input  logic [1:0] s,
  output logic [1:0] y
);
  always_comb begin
    y = 2'b00;
    case (s)
      2'd0: y = {a[0], a[1]};
      2'd1: y = {a[2], a[3]};
      2'd2: y = {a[4], a[5]};
      2'd3: y = {a[6], a[7]};
      default: y = 2'b00;
    endcase
  end
endmodule

// File: rtl/settle_timer.sv
// Settle counter: counts while enabled, done when the count reaches SETTLE_CYCLES-1.
module settle_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == LAST);
endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through four slots, samples each after a settle delay,
// and hands the reassembled 8-bit word downstream on a valid/ready handshake.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  output logic [1:0] sel,
  input  logic [1:0] mux_y,
  output logic       word_valid,
  input  logic       word_ready,
  output logic [7:0] word,
  output logic       busy,
  output logic [7:0] scan_count
);
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE_CYCLES must be in 1..255");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid, once high, holds with stable data until that transfer.
  state_t     state;
  logic [1:0] slot;
  logic       timer_done;
  logic       timer_en;
  logic       timer_clr;

  assign timer_en  = (state == SETTLE);
  assign timer_clr = (state != SETTLE);

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clr),
    .enable (timer_en),
    .done   (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= 2'd0;
      sel         <= 2'd0;
      word        <= 8'h00;
      word_valid  <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      scan_count  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state       <= SETTLE;
            slot        <= 2'd0;
            sel         <= 2'd0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SETTLE: begin
          if (timer_done) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          // Swap the pair back so word matches the mux a input bit order.
          word[{slot, 1'b0} +: 2] <= {mux_y[0], mux_y[1]};
          if (slot == SLOT_LAST) begin
            state      <= DONE;
            word_valid <= 1'b1;
          end else begin
            state <= SETTLE;
            slot  <= slot + 2'd1;
            sel   <= sel + 2'd1;
          end
        end
        DONE: begin
          if (word_ready) begin
            state       <= IDLE;
            word_valid  <= 1'b0;
            scan_count  <= scan_count + 8'd1;
            sel         <= 2'd0;
            slot        <= 2'd0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
